// File: rtl/lvds_scan_sequencer_if.sv
// rtl/lvds_scan_sequencer_if.sv - checker hookup and result-read bus of the LVDS scan sequencer
// master = sequencer side, slave = checker / result reader side.
interface lvds_scan_sequencer_if #(
  parameter int NCH = 8
);
  localparam int LW = (NCH > 1) ? $clog2(NCH) : 1;

  logic          chk_lvds;
  logic          chk_rst;
  logic          chk_ena;
  logic          chk_done;
  logic [7:0]    chk_err_cnt;
  logic [LW-1:0] rd_addr;
  logic [8:0]    rd_data;

  modport master (
    output chk_lvds, chk_rst, chk_ena, rd_data,
    input  chk_done, chk_err_cnt, rd_addr
  );

  modport slave (
    input  chk_lvds, chk_rst, chk_ena, rd_data,
    output chk_done, chk_err_cnt, rd_addr
  );
endinterface

// File: rtl/lvds_scan_sequencer.sv
// rtl/lvds_scan_sequencer.sv - walks masked LVDS lanes through one shared frame-counter checker
// Per lane: reset checker, force a zero run, run until done/timeout, store {timeout, err count}.
module lvds_scan_sequencer #(
  parameter int NCH        = 8,
  parameter int SETTLE_CYC = 24,
  parameter int TIMEOUT    = 6000,
  parameter int ERR_THRESH = 0,
  localparam int LW        = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 clk,
  input  logic                 syst_rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [NCH-1:0]       ch_mask,
  input  logic [NCH-1:0]       in_lvds,
  output logic                 busy,
  output logic                 done,
  output logic [LW-1:0]        cur_lane,
  output logic [NCH-1:0]       fail_mask,
  lvds_scan_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_RST, S_SETTLE, S_RUN, S_STORE, S_NEXT, S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [1:0]     rst_sync_q, rst_sync_d;
  logic [NCH-1:0] mask_q, mask_d;
  logic [NCH-1:0] fail_q, fail_d;
  logic [LW-1:0]  lane_q, lane_d;
  logic [15:0]    cnt_q, cnt_d;
  logic           to_q, to_d;
  logic           abort_q, abort_d;
  logic           chk_rst_q, chk_rst_d;
  logic           chk_lvds_q, chk_lvds_d;
  logic [8:0]     rd_data_q, rd_data_d;
  logic [8:0]     res_q [NCH];
  logic [8:0]     res_d [NCH];
  logic [LW:0]    lane_nx;

  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    fail_d     = fail_q;
    lane_d     = lane_q;
    cnt_d      = cnt_q;
    to_d       = to_q;
    abort_d    = abort_q;
    res_d      = res_q;
    chk_rst_d  = 1'b0;
    rst_sync_d = {rst_sync_q[0], 1'b1};
    lane_nx    = {1'b0, lane_q} + 1'b1;
    chk_lvds_d = (state_q == S_RUN) ? in_lvds[lane_q] : 1'b0;
    rd_data_d  = (32'(bus.rd_addr) < NCH) ? res_q[bus.rd_addr] : 9'h000;

    // Nothing moves until the released reset has crossed both synchroniser stages.
    if (rst_sync_q[1]) begin
      abort_d = abort;
      if (abort) begin
        state_d   = S_IDLE;
        cnt_d     = '0;
        chk_rst_d = !abort_q;
      end else begin
        case (state_q)
          S_IDLE, S_DONE: begin
            if (start) begin
              mask_d = ch_mask;
              fail_d = '0;
              res_d  = '{default: 9'h000};
              lane_d = '0;
              cnt_d  = '0;
              if (ch_mask == '0)   state_d = S_DONE;
              else if (ch_mask[0]) state_d = S_RST;
              else                 state_d = S_NEXT;
            end
          end
          S_RST: begin
            cnt_d   = '0;
            to_d    = 1'b0;
            state_d = S_SETTLE;
          end
          S_SETTLE: begin
            if (cnt_q == 16'(SETTLE_CYC - 1)) begin
              cnt_d   = '0;
              state_d = S_RUN;
            end else begin
              cnt_d = cnt_q + 16'd1;
            end
          end
          S_RUN: begin
            cnt_d = cnt_q + 16'd1;
            // A done arriving on the last allowed cycle still wins over the timeout.
            if (bus.chk_done) begin
              to_d    = 1'b0;
              state_d = S_STORE;
            end else if (cnt_q == 16'(TIMEOUT - 1)) begin
              to_d    = 1'b1;
              state_d = S_STORE;
            end
          end
          S_STORE: begin
            res_d[lane_q]  = to_q ? 9'h1FF : {1'b0, bus.chk_err_cnt};
            fail_d[lane_q] = to_q || (32'(bus.chk_err_cnt) > ERR_THRESH);
            state_d        = S_NEXT;
          end
          S_NEXT: begin
            if (32'(lane_nx) >= NCH) begin
              state_d = S_DONE;
            end else begin
              lane_d = lane_nx[LW-1:0];
              if (mask_q[lane_nx[LW-1:0]]) state_d = S_RST;
            end
          end
          default: state_d = S_IDLE;
        endcase
        if (state_d == S_RST) chk_rst_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge syst_rst_n) begin
    if (!syst_rst_n) begin
      state_q    <= S_IDLE;
      rst_sync_q <= '0;
      mask_q     <= '0;
      fail_q     <= '0;
      lane_q     <= '0;
      cnt_q      <= '0;
      to_q       <= 1'b0;
      abort_q    <= 1'b0;
      chk_rst_q  <= 1'b0;
      chk_lvds_q <= 1'b0;
      rd_data_q  <= '0;
      res_q      <= '{default: 9'h000};
    end else begin
      state_q    <= state_d;
      rst_sync_q <= rst_sync_d;
      mask_q     <= mask_d;
      fail_q     <= fail_d;
      lane_q     <= lane_d;
      cnt_q      <= cnt_d;
      to_q       <= to_d;
      abort_q    <= abort_d;
      chk_rst_q  <= chk_rst_d;
      chk_lvds_q <= chk_lvds_d;
      rd_data_q  <= rd_data_d;
      res_q      <= res_d;
    end
  end

  assign busy         = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done         = (state_q == S_DONE);
  assign cur_lane     = lane_q;
  assign fail_mask    = fail_q;
  assign bus.chk_ena  = (state_q == S_RUN);
  assign bus.chk_rst  = chk_rst_q;
  assign bus.chk_lvds = chk_lvds_q;
  assign bus.rd_data  = rd_data_q;

endmodule

// File: tb/tb_lvds_scan_sequencer.sv
// tb/tb_lvds_scan_sequencer.sv - randomized bench for lvds_scan_sequencer with a frame-checker model
// Expected results come from per-lane done/err tables and the lane mask.
module tb_lvds_scan_sequencer;
  localparam int NCH        = 8;
  localparam int SETTLE_CYC = 24;
  localparam int TIMEOUT    = 6000;
  localparam int ERR_THRESH = 0;
  localparam int NEVER      = 100000;

  logic           clk = 1'b0;
  logic           syst_rst_n = 1'b1;
  logic           start = 1'b0;
  logic           abort = 1'b0;
  logic [NCH-1:0] ch_mask = '0;
  logic [NCH-1:0] in_lvds = '0;
  logic           busy, done;
  logic [2:0]     cur_lane;
  logic [NCH-1:0] fail_mask;

  lvds_scan_sequencer_if #(.NCH(NCH)) ifc();

  lvds_scan_sequencer #(
    .NCH(NCH), .SETTLE_CYC(SETTLE_CYC), .TIMEOUT(TIMEOUT), .ERR_THRESH(ERR_THRESH)
  ) dut (
    .clk(clk), .syst_rst_n(syst_rst_n), .start(start), .abort(abort),
    .ch_mask(ch_mask), .in_lvds(in_lvds), .busy(busy), .done(done),
    .cur_lane(cur_lane), .fail_mask(fail_mask), .bus(ifc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int done_tab [NCH];
  int err_tab  [NCH];

  int   tested_q[$], runlen_q[$], settle_q[$];
  int   rst_pulses = 0, lvds_bad = 0, chk_cnt = 0, run_cnt = 0, settle_cnt = 0;
  bit   in_settle = 0;
  logic exp_lvds = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h exp 0x%0h", tag, got, exp);
    end
  endtask

  // Observer: lane order, settle length, run length, checker reset pulses.
  always @(posedge clk) begin
    exp_lvds = ifc.chk_ena ? in_lvds[cur_lane] : 1'b0;
    if (ifc.chk_rst) rst_pulses++;
    if (ifc.chk_rst && busy) begin
      tested_q.push_back(int'(cur_lane));
      in_settle  = 1;
      settle_cnt = 0;
    end else if (in_settle && !ifc.chk_ena) begin
      settle_cnt++;
    end else if (in_settle && ifc.chk_ena) begin
      settle_q.push_back(settle_cnt);
      in_settle = 0;
    end
    if (ifc.chk_ena) run_cnt++;
    else if (run_cnt > 0) begin
      runlen_q.push_back(run_cnt);
      run_cnt = 0;
    end
    if (ifc.chk_rst) chk_cnt = 0;
    else if (ifc.chk_ena) chk_cnt++;
  end

  // Checker model: raises done on the done_tab-th enabled cycle after its reset.
  always @(negedge clk) begin
    if (ifc.chk_lvds !== exp_lvds) lvds_bad++;
    in_lvds         = NCH'($urandom);
    ifc.chk_err_cnt = 8'(err_tab[cur_lane]);
    ifc.chk_done    = ifc.chk_ena && (chk_cnt == done_tab[cur_lane] - 1);
  end

  task automatic read_res(input int lane, input logic [8:0] exp);
    @(negedge clk);
    ifc.rd_addr = 3'(lane);
    @(negedge clk);
    check($sformatf("rd_data[%0d]", lane), ifc.rd_data, exp);
  endtask

  task automatic run_scan(input logic [NCH-1:0] mask, input bit restart);
    int             exp_lanes[$], exp_run[$];
    logic [8:0]     exp_res [NCH];
    logic [NCH-1:0] exp_fail;
    int             n, rst0;
    bit             to;
    exp_fail = '0;
    for (int i = 0; i < NCH; i++) begin
      exp_res[i] = 9'h000;
      if (mask[i]) begin
        to          = done_tab[i] > TIMEOUT;
        exp_res[i]  = to ? 9'h1FF : {1'b0, 8'(err_tab[i])};
        exp_fail[i] = to || (err_tab[i] > ERR_THRESH);
        exp_lanes.push_back(i);
        exp_run.push_back(to ? TIMEOUT : done_tab[i]);
      end
    end
    tested_q.delete(); runlen_q.delete(); settle_q.delete();
    @(negedge clk);
    lvds_bad = 0;
    rst0     = rst_pulses;
    ch_mask  = mask;
    start    = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    ch_mask = NCH'($urandom);
    if (mask == '0) check("zero_mask_done_next", done, 1);
    if (restart) begin
      repeat (10) @(negedge clk);
      ch_mask = ~mask;
      start   = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    n = 0;
    while (done !== 1'b1 && n < 60000) begin
      @(negedge clk);
      n++;
    end
    check("scan_done", done, 1);
    check("scan_busy", busy, 0);
    check("fail_mask", fail_mask, exp_fail);
    check("lanes_tested", tested_q.size(), exp_lanes.size());
    check("chk_rst_pulses", rst_pulses - rst0, exp_lanes.size());
    check("chk_lvds_path", lvds_bad, 0);
    for (int k = 0; k < exp_lanes.size(); k++) begin
      check($sformatf("lane_order%0d", k), (k < tested_q.size()) ? tested_q[k] : -1, exp_lanes[k]);
      check($sformatf("run_len%0d", k), (k < runlen_q.size()) ? runlen_q[k] : -1, exp_run[k]);
      check($sformatf("settle%0d", k), (k < settle_q.size()) ? settle_q[k] : -1, SETTLE_CYC);
    end
    for (int i = 0; i < NCH; i++) read_res(i, exp_res[i]);
  endtask

  initial begin
    int n, rst0;
    for (int i = 0; i < NCH; i++) begin
      done_tab[i] = NEVER;
      err_tab[i]  = 0;
    end
    ifc.chk_done    = 1'b0;
    ifc.chk_err_cnt = 8'h00;
    ifc.rd_addr     = 3'd0;
    #2 syst_rst_n = 1'b0;
    #1;
    check("rst_status", {busy, done, ifc.chk_ena, ifc.chk_rst, ifc.chk_lvds}, 0);
    check("rst_cur_lane", cur_lane, 0);
    check("rst_fail_mask", fail_mask, 0);
    check("rst_rd_data", ifc.rd_data, 0);
    repeat (3) @(negedge clk);
    syst_rst_n = 1'b1;
    repeat (4) @(negedge clk);

    run_scan(8'h00, 0);

    done_tab[0] = 4500; done_tab[2] = 4500;
    run_scan(8'h05, 0);

    done_tab[7] = 100; err_tab[7] = 3;
    run_scan(8'h80, 0);

    done_tab[1] = NEVER;
    run_scan(8'h02, 0);

    done_tab[4] = TIMEOUT; err_tab[4] = 0;
    done_tab[6] = TIMEOUT + 1; err_tab[6] = 0;
    run_scan(8'h50, 0);

    // Abort while lane 3 runs, with a competing start.
    done_tab[0] = 50; err_tab[0] = 1; done_tab[3] = NEVER; err_tab[3] = 0;
    @(negedge clk);
    ch_mask = 8'h09;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!(ifc.chk_ena && cur_lane == 3'd3) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("abort_reach_lane3", {ifc.chk_ena, cur_lane}, {1'b1, 3'd3});
    repeat (20) @(negedge clk);
    rst0    = rst_pulses;
    abort   = 1'b1;
    start   = 1'b1;
    ch_mask = 8'hFF;
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_ena", ifc.chk_ena, 0);
    check("abort_chk_rst", ifc.chk_rst, 1);
    check("abort_done", done, 0);
    repeat (10) @(negedge clk);
    check("abort_rst_pulses", rst_pulses - rst0, 1);
    check("abort_stays_idle", busy, 0);
    check("abort_fail_kept", fail_mask, 8'h01);
    read_res(0, 9'h001);
    read_res(3, 9'h000);

    // Reset mid-SETTLE of lane 1, between clock edges.
    done_tab[1] = 50;
    @(negedge clk);
    ch_mask = 8'h02;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!(ifc.chk_rst && busy) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("settle_reached", {ifc.chk_rst, busy}, 2'b11);
    repeat (6) @(negedge clk);
    #2 syst_rst_n = 1'b0;
    #1;
    check("midrst_status", {busy, done, ifc.chk_ena, ifc.chk_rst, ifc.chk_lvds}, 0);
    check("midrst_cur_lane", cur_lane, 0);
    @(negedge clk);
    rst0       = rst_pulses;
    syst_rst_n = 1'b1;
    ch_mask    = 8'h01;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("release_start_ignored", busy, 0);
    repeat (30) @(negedge clk);
    check("no_restart", busy, 0);
    check("no_rst_after_reset", rst_pulses - rst0, 0);

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < NCH; i++) begin
        done_tab[i] = int'($urandom_range(1, 300));
        err_tab[i]  = int'($urandom_range(0, 2));
      end
      if (r == 0) done_tab[$urandom_range(0, NCH - 1)] = NEVER;
      run_scan(NCH'($urandom_range(1, 255)), r > 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
